// File: rtl/clock_set_ctrl.sv
// Time-keeping controller: one-second advance strobe plus the button-driven
// HH:MM:SS time-set sequence that freezes the clock and loads the edited time.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  input  logic       cur_pm,
  output logic       ena,
  output logic       load,
  output logic [7:0] ld_hh,
  output logic [7:0] ld_mm,
  output logic [7:0] ld_ss,
  output logic       ld_pm,
  output logic [1:0] sel
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_SET_HH = 3'd1;
  localparam logic [2:0] ST_SET_MM = 3'd2;
  localparam logic [2:0] ST_SET_SS = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             mode_prev_q, mode_prev_d;
  logic             inc_prev_q, inc_prev_d;
  logic             mode_rise, inc_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ena_q, ena_d;
  logic             load_q, load_d;
  logic [7:0]       hh_q, hh_d;
  logic [7:0]       mm_q, mm_d;
  logic [7:0]       ss_q, ss_d;
  logic             pm_q, pm_d;

  // A simultaneous mode rise swallows the inc rise.
  always_comb begin
    mode_prev_d = btn_mode;
    inc_prev_d  = btn_inc;
    mode_rise   = btn_mode & ~mode_prev_q;
    inc_rise    = btn_inc & ~inc_prev_q & ~mode_rise;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (mode_rise) state_d = ST_SET_HH;
      ST_SET_HH: if (mode_rise) state_d = ST_SET_MM;
      ST_SET_MM: if (mode_rise) state_d = ST_SET_SS;
      ST_SET_SS: if (mode_rise) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // The prescaler only advances while RUN persists across the edge, so a
  // terminal count coinciding with entry into editing produces no tick.
  always_comb begin
    cnt_d = '0;
    ena_d = 1'b0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      if (cnt_q == CNT_LAST) begin
        ena_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    load_d = (state_d == ST_COMMIT);
  end

  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    pm_d = pm_q;
    if (state_q == ST_RUN && mode_rise) begin
      hh_d = cur_hh;
      mm_d = cur_mm;
      ss_d = cur_ss;
      pm_d = cur_pm;
    end else if (inc_rise) begin
      case (state_q)
        ST_SET_HH: begin
          if (hh_q == 8'd12) begin
            hh_d = 8'd1;
          end else if (hh_q == 8'd11) begin
            hh_d = 8'd12;
            pm_d = ~pm_q;
          end else begin
            hh_d = hh_q + 8'd1;
          end
        end
        ST_SET_MM: mm_d = (mm_q == 8'd59) ? 8'd0 : mm_q + 8'd1;
        ST_SET_SS: ss_d = 8'd0;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_SET_HH: sel = 2'd1;
      ST_SET_MM: sel = 2'd2;
      ST_SET_SS: sel = 2'd3;
      default:   sel = 2'd0;
    endcase
  end

  // Button history resets high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      cnt_q       <= '0;
      ena_q       <= 1'b0;
      load_q      <= 1'b0;
      hh_q        <= 8'd6;
      mm_q        <= 8'd0;
      ss_q        <= 8'd0;
      pm_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_prev_d;
      inc_prev_q  <= inc_prev_d;
      cnt_q       <= cnt_d;
      ena_q       <= ena_d;
      load_q      <= load_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      pm_q        <= pm_d;
    end
  end

  assign ena   = ena_q;
  assign load  = load_q;
  assign ld_hh = hh_q;
  assign ld_mm = mm_q;
  assign ld_ss = ss_q;
  assign ld_pm = pm_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios with fixed
// expectations, then random buttons/time checked against a behavioural model.
module tb_clock_set_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] cur_hh = 8'd1;
  logic [7:0] cur_mm = 8'd0;
  logic [7:0] cur_ss = 8'd0;
  logic       cur_pm = 1'b0;
  logic       ena, load, ld_pm;
  logic [7:0] ld_hh, ld_mm, ld_ss;
  logic [1:0] sel;

  int checks = 0;
  int failures = 0;

  clock_set_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss), .cur_pm(cur_pm),
    .ena(ena), .load(load), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .ld_pm(ld_pm), .sel(sel)
  );

  always #5 clk = ~clk;

  // Behavioural reference: field index 0 RUN, 1..3 editing, 4 commit;
  // ticks fall every TICK_DIV cycles spent continuously in RUN.
  int m_field = 0;
  int m_hh = 6, m_mm = 0, m_ss = 0;
  int m_run_cycles = 0;
  bit m_pm = 0, m_prev_mode = 1, m_prev_inc = 1, m_ena = 0, m_load = 0;

  always @(posedge clk) begin : ref_model
    bit mr, ir;
    int nxt;
    if (reset) begin
      m_field = 0; m_hh = 6; m_mm = 0; m_ss = 0; m_pm = 0;
      m_prev_mode = 1; m_prev_inc = 1; m_run_cycles = 0; m_ena = 0; m_load = 0;
    end else begin
      mr = btn_mode && !m_prev_mode;
      ir = btn_inc && !m_prev_inc && !mr;
      m_prev_mode = btn_mode;
      m_prev_inc = btn_inc;
      if (m_field == 4) nxt = 0;
      else if (mr) nxt = m_field + 1;
      else nxt = m_field;
      if (m_field == 0 && mr) begin
        m_hh = int'(cur_hh); m_mm = int'(cur_mm); m_ss = int'(cur_ss); m_pm = cur_pm;
      end
      if (ir && m_field == 1) begin
        m_hh = m_hh % 12 + 1;
        if (m_hh == 12) m_pm = !m_pm;
      end
      if (ir && m_field == 2) m_mm = (m_mm + 1) % 60;
      if (ir && m_field == 3) m_ss = 0;
      if (m_field == 0 && nxt == 0) begin
        m_run_cycles++;
        m_ena = (m_run_cycles % TICK_DIV) == 0;
      end else begin
        m_run_cycles = 0;
        m_ena = 0;
      end
      m_load = (nxt == 4);
      m_field = nxt;
    end
  end

  // One idle cycle with buttons low, then one cycle with the requested levels.
  task automatic press(input bit m, input bit i);
    btn_mode = 0; btn_inc = 0;
    @(negedge clk);
    btn_mode = m; btn_inc = i;
    @(negedge clk);
    btn_mode = 0; btn_inc = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ena, load, sel} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got ena/load/sel=%b expected 0000", {ena, load, sel});
    end
    checks++;
    if ({ld_hh, ld_mm, ld_ss, ld_pm} !== {8'd6, 8'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_time: got %0d:%0d:%0d pm=%0d expected 6:0:0 pm=0",
               ld_hh, ld_mm, ld_ss, ld_pm);
    end
    reset = 0;
  endtask

  task automatic test_ticks();
    int pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ena) pulses++;
      checks++;
      if ({ena, load, sel} !== {(k % TICK_DIV) == 0, 1'b0, 2'd0}) begin
        failures++;
        $display("[TB] FAIL tick_cycle%0d: got ena/load/sel=%b expected ena=%0d load=0 sel=0",
                 k, {ena, load, sel}, (k % TICK_DIV) == 0);
      end
    end
    checks++;
    if (pulses != 20 / TICK_DIV) begin
      failures++;
      $display("[TB] FAIL tick_count: got %0d expected %0d", pulses, 20 / TICK_DIV);
    end
  endtask

  task automatic test_full_sequence();
    cur_hh = 8'd11; cur_mm = 8'd58; cur_ss = 8'd30; cur_pm = 1'b0;
    press(1, 0);
    checks++;
    if ({sel, ld_hh, ld_mm, ld_ss, ld_pm} !== {2'd1, 8'd11, 8'd58, 8'd30, 1'b0}) begin
      failures++;
      $display("[TB] FAIL seq_enter: got sel=%0d %0d:%0d:%0d pm=%0d expected sel=1 11:58:30 pm=0",
               sel, ld_hh, ld_mm, ld_ss, ld_pm);
    end
    press(0, 1);
    checks++;
    if ({ld_hh, ld_pm} !== {8'd12, 1'b1}) begin
      failures++;
      $display("[TB] FAIL seq_hh_11to12: got hh=%0d pm=%0d expected hh=12 pm=1", ld_hh, ld_pm);
    end
    press(0, 1);
    checks++;
    if ({ld_hh, ld_pm} !== {8'd1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL seq_hh_12to1: got hh=%0d pm=%0d expected hh=1 pm=1", ld_hh, ld_pm);
    end
    press(1, 0);
    press(0, 1);
    press(0, 1);
    checks++;
    if ({sel, ld_hh, ld_mm} !== {2'd2, 8'd1, 8'd0}) begin
      failures++;
      $display("[TB] FAIL seq_mm_wrap: got sel=%0d hh=%0d mm=%0d expected sel=2 hh=1 mm=0",
               sel, ld_hh, ld_mm);
    end
    press(1, 0);
    press(0, 1);
    checks++;
    if ({sel, ld_ss} !== {2'd3, 8'd0}) begin
      failures++;
      $display("[TB] FAIL seq_ss_clear: got sel=%0d ss=%0d expected sel=3 ss=0", sel, ld_ss);
    end
    press(1, 0);
    checks++;
    if ({ena, load, sel, ld_hh, ld_mm, ld_ss, ld_pm} !==
        {1'b0, 1'b1, 2'd0, 8'd1, 8'd0, 8'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL seq_commit: got ena=%0d load=%0d sel=%0d %0d:%0d:%0d pm=%0d expected load=1 sel=0 1:0:0 pm=1",
               ena, load, sel, ld_hh, ld_mm, ld_ss, ld_pm);
    end
    @(negedge clk);
    checks++;
    if ({load, sel} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL seq_after_commit: got load=%0d sel=%0d expected 0 0", load, sel);
    end
  endtask

  task automatic test_freeze();
    press(1, 0);
    press(1, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checks++;
      if ({ena, sel} !== {1'b0, 2'd2}) begin
        failures++;
        $display("[TB] FAIL freeze_cycle%0d: got ena=%0d sel=%0d expected ena=0 sel=2", k, ena, sel);
      end
    end
    press(1, 0);
    press(1, 0);
    checks++;
    if (load !== 1'b1) begin
      failures++;
      $display("[TB] FAIL freeze_commit: got load=%0d expected 1", load);
    end
    for (int k = 1; k <= TICK_DIV + 1; k++) begin
      @(negedge clk);
      checks++;
      if ({ena, load} !== {k == TICK_DIV + 1, 1'b0}) begin
        failures++;
        $display("[TB] FAIL resume_tick%0d: got ena=%0d load=%0d expected ena=%0d load=0",
                 k, ena, load, k == TICK_DIV + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    cur_hh = 8'd4; cur_mm = 8'd20; cur_ss = 8'd15; cur_pm = 1'b1;
    press(1, 0);
    press(1, 1);
    checks++;
    if ({sel, ld_hh, ld_pm} !== {2'd2, 8'd4, 1'b1}) begin
      failures++;
      $display("[TB] FAIL simult_mode_wins: got sel=%0d hh=%0d pm=%0d expected sel=2 hh=4 pm=1",
               sel, ld_hh, ld_pm);
    end
    @(negedge clk);
    btn_inc = 1;
    repeat (10) @(negedge clk);
    btn_inc = 0;
    @(negedge clk);
    checks++;
    if ({sel, ld_mm} !== {2'd2, 8'd21}) begin
      failures++;
      $display("[TB] FAIL held_inc_once: got sel=%0d mm=%0d expected sel=2 mm=21", sel, ld_mm);
    end
    press(1, 0);
    press(1, 0);
    checks++;
    if ({load, ld_hh, ld_mm, ld_ss, ld_pm} !== {1'b1, 8'd4, 8'd21, 8'd15, 1'b1}) begin
      failures++;
      $display("[TB] FAIL held_commit: got load=%0d %0d:%0d:%0d pm=%0d expected load=1 4:21:15 pm=1",
               load, ld_hh, ld_mm, ld_ss, ld_pm);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_edit();
    cur_hh = 8'd9; cur_mm = 8'd10; cur_ss = 8'd11; cur_pm = 1'b0;
    press(1, 0);
    press(1, 0);
    repeat (3) press(0, 1);
    checks++;
    if ({sel, ld_mm} !== {2'd2, 8'd13}) begin
      failures++;
      $display("[TB] FAIL midedit_before: got sel=%0d mm=%0d expected sel=2 mm=13", sel, ld_mm);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if ({ena, load, sel, ld_hh, ld_mm, ld_ss, ld_pm} !==
        {1'b0, 1'b0, 2'd0, 8'd6, 8'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midedit_reset: got ena=%0d load=%0d sel=%0d %0d:%0d:%0d pm=%0d expected 0 0 0 6:0:0 pm=0",
               ena, load, sel, ld_hh, ld_mm, ld_ss, ld_pm);
    end
    for (int k = 1; k <= TICK_DIV; k++) begin
      @(negedge clk);
      checks++;
      if ({ena, load} !== {k == TICK_DIV, 1'b0}) begin
        failures++;
        $display("[TB] FAIL midedit_tick%0d: got ena=%0d load=%0d expected ena=%0d load=0",
                 k, ena, load, k == TICK_DIV);
      end
    end
  endtask

  task automatic test_held_through_reset();
    btn_mode = 1;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (sel !== 2'd0) begin
        failures++;
        $display("[TB] FAIL held_reset_cycle%0d: got sel=%0d expected 0", k, sel);
      end
    end
    btn_mode = 0;
    @(negedge clk);
    btn_mode = 1;
    @(negedge clk);
    btn_mode = 0;
    checks++;
    if (sel !== 2'd1) begin
      failures++;
      $display("[TB] FAIL held_reset_repress: got sel=%0d expected 1", sel);
    end
    repeat (3) press(1, 0);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [28:0] obs, exp;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 4) == 0) btn_inc = ~btn_inc;
      cur_hh = 8'($urandom_range(1, 12));
      cur_mm = 8'($urandom_range(0, 59));
      cur_ss = 8'($urandom_range(0, 59));
      cur_pm = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      obs = {ena, load, sel, ld_hh, ld_mm, ld_ss, ld_pm};
      exp = {m_ena, m_load, (m_field >= 1 && m_field <= 3) ? 2'(m_field) : 2'd0,
             8'(m_hh), 8'(m_mm), 8'(m_ss), m_pm};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", k, obs, exp);
      end
      checks++;
      if (ena && load) begin
        failures++;
        $display("[TB] FAIL random_exclusive%0d: got ena=1 load=1 expected not both", k);
      end
    end
    reset = 0;
    btn_mode = 0;
    btn_inc = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ticks();
    test_full_sequence();
    test_freeze();
    test_back_to_back();
    test_reset_mid_edit();
    test_held_through_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-keeping controller for the 12-hour HH:MM:SS clock datapath. It generates the one-second advance strobe (`ena`) from the system clock and runs the user time-set sequence from two debounced push-buttons. While the user is editing, it freezes the clock. On exit it issues a one-cycle `load` with the edited time. It sits between the button debouncers and the clock core; the core's `load` has priority over its `ena`.

## Interface

- `TICK_DIV`, default 50_000_000 — system-clock cycles per one-second `ena` pulse; ≥ 2; prescaler width = clog2(TICK_DIV).
- `clk`  in  1  — single system clock, all logic on rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `btn_mode`  in  1  — debounced level; rising edge advances the set sequence.
- `btn_inc`  in  1  — debounced level; rising edge increments the selected field.
- `cur_hh`, `cur_mm`, `cur_ss`  in  8 each  — live time from the clock core (binary, hh 1..12).
- `cur_pm`  in  1  — live AM/PM from the clock core.
- `ena`  out  1  — one-cycle advance strobe to the clock core; registered.
- `load`  out  1  — one-cycle strobe; clock core takes `ld_*` on this cycle; registered.
- `ld_hh`, `ld_mm`, `ld_ss`  out  8 each  — edited time; valid and stable whenever `load`=1.
- `ld_pm`  out  1  — edited AM/PM.
- `sel`  out  2  — current field: 0 RUN, 1 hours, 2 minutes, 3 seconds; COMMIT shows 0.

## Operation

- **Edge detect:** keep a registered previous value per button; `rise = btn & ~prev`. On reset, `prev` is set to 1, so a button held through reset produces no edge.
- **State machine:** RUN → SET_HH → SET_MM → SET_SS → COMMIT → RUN.
  - RUN→SET_HH on a `btn_mode` rise. On the same edge, the edit regs capture `cur_hh/mm/ss/pm`.
  - SET_HH→SET_MM and SET_MM→SET_SS on a `btn_mode` rise.
  - SET_SS→COMMIT on a `btn_mode` rise.
  - COMMIT→RUN unconditionally after 1 cycle.
- **Field increments** (on a `btn_inc` rise, only in the matching state):
  - SET_HH: 12→1; 11→12 also toggles `ld_pm`; otherwise +1.
  - SET_MM: 59→0 with no carry into hours; otherwise +1.
  - SET_SS: any `btn_inc` rise clears seconds to 0.
- A `btn_inc` rise in RUN or COMMIT is ignored.
- If `btn_mode` and `btn_inc` rise on the same edge, mode wins and inc is discarded.
- **Prescaler:**
  - Counts only in RUN, from 0 to TICK_DIV-1, then wraps to 0.
  - `ena`=1 in the cycle after the count hits TICK_DIV-1, i.e. one pulse every TICK_DIV cycles.
  - In all non-RUN states the prescaler is held at 0 and `ena`=0.
  - Leaving RUN in the same edge as a pending terminal count suppresses that tick.
- `load`=1 exactly during COMMIT. `ena` and `load` never assert together.
- **Reset values:**
  - state RUN, `sel`=0, prescaler 0, `ena`=0, `load`=0.
  - Edit regs 6, 0, 0, `ld_pm`=0 (matches the clock core reset).
- Reset mid-edit discards the edits with no `load`. Counting restarts from 0.
- Edit regs hold their value outside editing; `ld_*` hold their last value between loads.

## Timing

- Button rise sampled at edge n → `sel` and state change visible after edge n. An edit-reg increment is visible after edge n.
- First `ena` after reset: high in the cycle following edge TICK_DIV, i.e. prescaler wraps at edge TICK_DIV and `ena` is registered.
- COMMIT entered at edge n → `load`=1 for the cycle between edges n and n+1. RUN resumes at n+1.
- The prescaler restarts from 0 at n+1. The next `ena` comes TICK_DIV cycles later.
- Latency from `btn_mode` rise in SET_SS to `load`: 1 edge.
- Edit-reg update to `ld_*` output: same edge (direct register outputs).

## Test plan

- **Reset and ticks:** TICK_DIV=4, reset then idle 20 cycles → `ena` pulses every 4 cycles, each 1 cycle wide; `load`=0 and `sel`=0 throughout.
- **Full set sequence:** cur=11:58:30 AM.
  - mode → `sel`=1 and `ld_*`=11:58:30, pm=0.
  - inc → 12, pm=1; inc → 1, pm=1.
  - mode; inc ×2 → mm=0.
  - mode; inc → ss=0.
  - mode → `load`=1 for 1 cycle with 01:00:00 PM.
- **Freeze:** during SET_MM, hold 50 cycles → `ena` stays 0. After COMMIT, first `ena` arrives exactly 4 cycles after RUN resumes.
- **Simultaneous and held buttons:**
  - mode and inc rise on the same edge in SET_HH → `sel`=2, hh unchanged.
  - `btn_inc` held high for 10 cycles → exactly one increment.
- **Reset mid-edit:** enter SET_MM, inc ×3, assert reset → `sel`=0, `load` never pulses, `ld_*`=06:00:00 AM, next `ena` comes 4 cycles after reset release.
- **Button held through reset:** `btn_mode` high before and after reset → no state change until it falls and rises again.
